// File: rtl/cpu_pkg.sv
// Shared encodings for the memory/writeback stage: opcodes, I-type sub-ops, FSM states
// and instruction field positions.
package cpu_pkg;

   typedef enum logic [1:0] {
      OP_R    = 2'b00,
      OP_I    = 2'b01,
      OP_JMP  = 2'b10,
      OP_HALT = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      I_ADDI = 2'b00,
      I_LD   = 2'b01,
      I_ST   = 2'b10,
      I_CMP  = 2'b11
   } isub_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      MEM_WAIT = 2'b01,
      HALTED   = 2'b10
   } state_e;

   localparam int INSTR_W = 8;
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 6;
   localparam int SUB_MSB = 5;
   localparam int SUB_LSB = 4;
   localparam int RT_MSB  = 3;
   localparam int RT_LSB  = 2;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack engine: holds the request until ack (or timeout) and reports completion.
// Optional timeout counter is enabled by defining MEM_TIMEOUT_EN.
module dmem_handshake #(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              o_done,
   output logic              o_timed_out,
   output logic [DATA_W-1:0] o_rdata
);

   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   // ack is only meaningful while the request is up
   assign o_done  = r_req & dmem_ack;
   assign o_rdata = dmem_rdata;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] r_cnt;

   // an ack on the final count takes priority over the timeout
   assign o_timed_out = r_req & ~dmem_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= '0;
      end else if (r_req) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
   assign o_timed_out      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (i_start) begin
         r_req   <= 1'b1;
         r_we    <= i_we;
         r_addr  <= i_addr;
         r_wdata <= i_wdata;
      end else if (o_done || o_timed_out) begin
         r_req <= 1'b0;
      end
   end

   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: LD/ST via req/ack port, register writeback, jump redirect, halt.
// Define MEM_TIMEOUT_EN to bound the wait for dmem_ack and raise a sticky mem_err.
module mem_wb_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [DATA_W-1:0]  alu_result_in,
   input  logic [DATA_W-1:0]  write_data_in,
   input  logic [7:0]         pc_alu_in,
   output logic               stall_out,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [ADDR_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_ack,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic               wb_en,
   output logic [1:0]         wb_reg,
   output logic [DATA_W-1:0]  wb_data,
   output logic               redirect_valid,
   output logic [7:0]         redirect_pc,
   output logic               halted,
   output logic               mem_err
);

   state_e              r_state, w_state_nxt;
   logic                r_wb_en, w_wb_en_nxt;
   logic [1:0]          r_wb_reg, w_wb_reg_nxt;
   logic [DATA_W-1:0]   r_wb_data, w_wb_data_nxt;
   logic                r_redir_vld, w_redir_vld_nxt;
   logic [7:0]          r_redir_pc, w_redir_pc_nxt;
   logic                r_halted, w_halted_nxt;
   logic                r_is_ld, w_is_ld_nxt;
   logic [1:0]          r_rt, w_rt_nxt;

   logic                w_start, w_start_we;
   logic                w_hs_done, w_hs_timed_out;
   logic [DATA_W-1:0]   w_hs_rdata;
   logic [ADDR_W-1:0]   w_addr;

   opcode_e             w_opcode;
   isub_e               w_sub;
   logic [1:0]          w_rt;
   logic                w_unused;

   assign w_opcode = opcode_e'(instr_in[OPC_MSB:OPC_LSB]);
   assign w_sub    = isub_e'(instr_in[SUB_MSB:SUB_LSB]);
   assign w_rt     = instr_in[RT_MSB:RT_LSB];
   assign w_unused = &{1'b0, instr_in[RT_LSB-1:0]};

   generate
      if (ADDR_W <= DATA_W) begin : g_addr_trunc
         assign w_addr = alu_result_in[ADDR_W-1:0];
      end else begin : g_addr_zext
         assign w_addr = {{(ADDR_W-DATA_W){1'b0}}, alu_result_in};
      end
   endgenerate

   dmem_handshake #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_dmem_hs (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_start),
      .i_we        (w_start_we),
      .i_addr      (w_addr),
      .i_wdata     (write_data_in),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .o_done      (w_hs_done),
      .o_timed_out (w_hs_timed_out),
      .o_rdata     (w_hs_rdata)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_wb_en_nxt     = 1'b0;
      w_wb_reg_nxt    = r_wb_reg;
      w_wb_data_nxt   = r_wb_data;
      w_redir_vld_nxt = 1'b0;
      w_redir_pc_nxt  = r_redir_pc;
      w_halted_nxt    = r_halted;
      w_is_ld_nxt     = r_is_ld;
      w_rt_nxt        = r_rt;
      w_start         = 1'b0;
      w_start_we      = 1'b0;
      case (r_state)
         IDLE: begin
            if (valid_in) begin
               case (w_opcode)
                  OP_R: begin
                     w_wb_en_nxt   = 1'b1;
                     w_wb_reg_nxt  = instr_in[SUB_MSB:SUB_LSB];
                     w_wb_data_nxt = alu_result_in;
                  end
                  OP_I: begin
                     if (w_sub == I_LD || w_sub == I_ST) begin
                        w_start     = 1'b1;
                        w_start_we  = (w_sub == I_ST);
                        w_is_ld_nxt = (w_sub == I_LD);
                        w_rt_nxt    = w_rt;
                        w_state_nxt = MEM_WAIT;
                     end else begin
                        w_wb_en_nxt   = 1'b1;
                        w_wb_reg_nxt  = w_rt;
                        w_wb_data_nxt = alu_result_in;
                     end
                  end
                  OP_JMP: begin
                     w_redir_vld_nxt = 1'b1;
                     w_redir_pc_nxt  = pc_alu_in;
                  end
                  default: begin
                     w_halted_nxt = 1'b1;
                     w_state_nxt  = HALTED;
                  end
               endcase
            end
         end
         MEM_WAIT: begin
            if (w_hs_done) begin
               w_state_nxt = IDLE;
               if (r_is_ld) begin
                  w_wb_en_nxt   = 1'b1;
                  w_wb_reg_nxt  = r_rt;
                  w_wb_data_nxt = w_hs_rdata;
               end
            end else if (w_hs_timed_out) begin
               // a timed-out load still retires, with zero data
               w_state_nxt = IDLE;
               if (r_is_ld) begin
                  w_wb_en_nxt   = 1'b1;
                  w_wb_reg_nxt  = r_rt;
                  w_wb_data_nxt = '0;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_wb_en     <= 1'b0;
         r_wb_reg    <= '0;
         r_wb_data   <= '0;
         r_redir_vld <= 1'b0;
         r_redir_pc  <= '0;
         r_halted    <= 1'b0;
         r_is_ld     <= 1'b0;
         r_rt        <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wb_en     <= w_wb_en_nxt;
         r_wb_reg    <= w_wb_reg_nxt;
         r_wb_data   <= w_wb_data_nxt;
         r_redir_vld <= w_redir_vld_nxt;
         r_redir_pc  <= w_redir_pc_nxt;
         r_halted    <= w_halted_nxt;
         r_is_ld     <= w_is_ld_nxt;
         r_rt        <= w_rt_nxt;
      end
   end

`ifdef MEM_TIMEOUT_EN
   logic r_mem_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_err <= 1'b0;
      end else if (w_hs_timed_out) begin
         r_mem_err <= 1'b1;
      end
   end
   assign mem_err = r_mem_err;
`else
   assign mem_err = 1'b0;
`endif

   assign stall_out      = (r_state != IDLE);
   assign wb_en          = r_wb_en;
   assign wb_reg         = r_wb_reg;
   assign wb_data        = r_wb_data;
   assign redirect_valid = r_redir_vld;
   assign redirect_pc    = r_redir_pc;
   assign halted         = r_halted;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU writeback, LD/ST handshake, jump, halt, async reset,
// and (with MEM_TIMEOUT_EN) the ack timeout.
module tb_mem_wb_stage;

   logic       clk;
   logic       rst_n;
   logic       valid_in;
   logic [7:0] instr_in;
   logic [7:0] alu_result_in;
   logic [7:0] write_data_in;
   logic [7:0] pc_alu_in;
   logic       stall_out;
   logic       dmem_req;
   logic       dmem_we;
   logic [7:0] dmem_addr;
   logic [7:0] dmem_wdata;
   logic       dmem_ack;
   logic [7:0] dmem_rdata;
   logic       wb_en;
   logic [1:0] wb_reg;
   logic [7:0] wb_data;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic       halted;
   logic       mem_err;

   int n_checks = 0;
   int n_errors = 0;

   mem_wb_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .instr_in       (instr_in),
      .alu_result_in  (alu_result_in),
      .write_data_in  (write_data_in),
      .pc_alu_in      (pc_alu_in),
      .stall_out      (stall_out),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .wb_en          (wb_en),
      .wb_reg         (wb_reg),
      .wb_data        (wb_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .mem_err        (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] ins, input logic [7:0] alu);
      valid_in      = v;
      instr_in      = ins;
      alu_result_in = alu;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00);
      write_data_in = 8'h00;
      pc_alu_in     = 8'h00;
      dmem_ack      = 1'b0;
      dmem_rdata    = 8'h00;
      #3;
      check("rst_stall", stall_out, 0);
      check("rst_req", dmem_req, 0);
      check("rst_wb_en", wb_en, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_redirect", redirect_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_mem_err", mem_err, 0);
      tick();
      rst_n = 1'b1;

      // R-type ADD, rd = 1
      drive(1'b1, 8'h18, 8'h2A);
      #1;
      check("r_stall_pre", stall_out, 0);
      tick();
      check("r_wb_en", wb_en, 1);
      check("r_wb_reg", wb_reg, 1);
      check("r_wb_data", wb_data, 8'h2A);
      check("r_stall", stall_out, 0);

      // back-to-back: ADDI rt=2, CMP rt=1 (FF), R-type to register 0
      drive(1'b1, 8'h48, 8'h11);
      tick();
      check("addi_wb_en", wb_en, 1);
      check("addi_wb_reg", wb_reg, 2);
      check("addi_wb_data", wb_data, 8'h11);
      drive(1'b1, 8'h74, 8'hFF);
      tick();
      check("cmp_wb_reg", wb_reg, 1);
      check("cmp_wb_data", wb_data, 8'hFF);
      drive(1'b1, 8'h00, 8'h05);
      tick();
      check("r0_wb_en", wb_en, 1);
      check("r0_wb_reg", wb_reg, 0);
      check("r0_wb_data", wb_data, 8'h05);
      drive(1'b0, 8'h00, 8'h00);
      tick();
      check("idle_wb_en", wb_en, 0);
      check("idle_wb_reg_hold", wb_reg, 0);
      check("idle_wb_data_hold", wb_data, 8'h05);

      // LD rt=3 @0x40, ack in the third request cycle
      drive(1'b1, 8'h5C, 8'h40);
      tick();
      check("ld_req1", dmem_req, 1);
      check("ld_addr", dmem_addr, 8'h40);
      check("ld_we", dmem_we, 0);
      check("ld_stall1", stall_out, 1);
      check("ld_wb_en1", wb_en, 0);
      drive(1'b1, 8'h18, 8'hEE);
      tick();
      check("ld_req2", dmem_req, 1);
      check("ld_addr2", dmem_addr, 8'h40);
      check("ld_stall2", stall_out, 1);
      check("ld_wb_en2", wb_en, 0);
      tick();
      check("ld_req3", dmem_req, 1);
      check("ld_stall3", stall_out, 1);
      check("ld_wb_en3", wb_en, 0);
      dmem_ack   = 1'b1;
      dmem_rdata = 8'h99;
      tick();
      dmem_ack = 1'b0;
      drive(1'b0, 8'h00, 8'h00);
      check("ld_req_drop", dmem_req, 0);
      check("ld_wb_en", wb_en, 1);
      check("ld_wb_reg", wb_reg, 3);
      check("ld_wb_data", wb_data, 8'h99);
      check("ld_stall_done", stall_out, 0);
      tick();
      check("ld_wb_pulse", wb_en, 0);

      // ST @0x10 data 0x77, ack in the first request cycle, next instr right after
      drive(1'b1, 8'h60, 8'h10);
      write_data_in = 8'h77;
      tick();
      check("st_req", dmem_req, 1);
      check("st_we", dmem_we, 1);
      check("st_addr", dmem_addr, 8'h10);
      check("st_wdata", dmem_wdata, 8'h77);
      dmem_ack = 1'b1;
      drive(1'b1, 8'h28, 8'h33);
      tick();
      dmem_ack = 1'b0;
      check("st_req_drop", dmem_req, 0);
      check("st_no_wb", wb_en, 0);
      check("st_stall_done", stall_out, 0);
      tick();
      check("st_next_wb_en", wb_en, 1);
      check("st_next_wb_reg", wb_reg, 2);
      check("st_next_wb_data", wb_data, 8'h33);

      // JMP then HALT, then ignored traffic
      drive(1'b1, 8'h85, 8'h00);
      pc_alu_in = 8'h05;
      tick();
      check("jmp_redirect", redirect_valid, 1);
      check("jmp_pc", redirect_pc, 8'h05);
      check("jmp_no_wb", wb_en, 0);
      drive(1'b1, 8'hC0, 8'h00);
      tick();
      check("halt_redirect_pulse", redirect_valid, 0);
      check("halt_flag", halted, 1);
      check("halt_stall", stall_out, 1);
      drive(1'b1, 8'h18, 8'h44);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halted_no_wb", wb_en, 0);
         check("halted_sticky", halted, 1);
         check("halted_stall", stall_out, 1);
         check("halted_no_req", dmem_req, 0);
      end

      // async reset out of HALTED, then reset in the middle of MEM_WAIT
      #2;
      rst_n = 1'b0;
      #1;
      check("rst2_halted", halted, 0);
      check("rst2_stall", stall_out, 0);
      tick();
      rst_n = 1'b1;
      drive(1'b1, 8'h5C, 8'h20);
      tick();
      check("rst_ld_req", dmem_req, 1);
      drive(1'b0, 8'h00, 8'h00);
      dmem_ack   = 1'b1;
      dmem_rdata = 8'hAA;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", dmem_req, 0);
      check("rst_mid_stall", stall_out, 0);
      tick();
      rst_n    = 1'b1;
      dmem_ack = 1'b0;
      tick();
      check("rst_after_wb_en", wb_en, 0);
      check("rst_after_req", dmem_req, 0);
      check("rst_after_stall", stall_out, 0);

`ifdef MEM_TIMEOUT_EN
      // LD with no ack: request held 16 cycles, then zero writeback and mem_err
      drive(1'b1, 8'h5C, 8'h30);
      tick();
      drive(1'b0, 8'h00, 8'h00);
      for (int i = 1; i < 16; i++) begin
         check("to_req_held", dmem_req, 1);
         tick();
      end
      check("to_req_last", dmem_req, 1);
      check("to_err_before", mem_err, 0);
      tick();
      check("to_req_drop", dmem_req, 0);
      check("to_mem_err", mem_err, 1);
      check("to_wb_en", wb_en, 1);
      check("to_wb_reg", wb_reg, 3);
      check("to_wb_data", wb_data, 8'h00);
      check("to_stall", stall_out, 0);
`else
      // LD with no ack waits indefinitely; mem_err never rises
      drive(1'b1, 8'h5C, 8'h30);
      tick();
      drive(1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 20; i++) tick();
      check("nto_req_held", dmem_req, 1);
      check("nto_stall", stall_out, 1);
      check("nto_mem_err", mem_err, 0);
      dmem_ack   = 1'b1;
      dmem_rdata = 8'h5A;
      tick();
      dmem_ack = 1'b0;
      check("nto_wb_data", wb_data, 8'h5A);
      check("nto_req_drop", dmem_req, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Stage directly downstream of the execute stage.
- Consumes the registered ALU result, store data and jump target, plus the instruction aligned with them.
- Performs LD/ST through a req/ack data-memory port and stalls upstream while a memory access is outstanding.
- Emits a one-cycle register writeback pulse, a jump redirect pulse to fetch, and a sticky halted flag.

Parameters:
- DATA_W, 8, datapath width.
- ADDR_W, 8, data-memory address width; address is alu_result_in[ADDR_W-1:0].
- TIMEOUT_CYCLES, 16, maximum wait for dmem_ack; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  inputs below carry an instruction this cycle.
- instr_in  input  8  instruction aligned with the execute outputs. opcode[7:6], sub/rs[5:4], rt[3:2], funct/imm[1:0].
- alu_result_in  input  DATA_W  ALU result, or memory address for LD/ST.
- write_data_in  input  DATA_W  store data.
- pc_alu_in  input  8  jump target.
- stall_out  output  1  upstream must hold its inputs. Combinational: state != IDLE.
- dmem_req  output  1  memory request, registered.
- dmem_we  output  1  1 = store.
- dmem_addr  output  ADDR_W  request address.
- dmem_wdata  output  DATA_W  store data.
- dmem_ack  input  1  request complete. Valid only while dmem_req = 1.
- dmem_rdata  input  DATA_W  load data, valid with dmem_ack.
- wb_en  output  1  register-file write pulse.
- wb_reg  output  2  destination register.
- wb_data  output  DATA_W  writeback value.
- redirect_valid  output  1  jump pulse.
- redirect_pc  output  8  jump target.
- halted  output  1  sticky halt flag.
- mem_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset is asynchronous and drops dmem_req immediately; an in-flight access is discarded with no writeback.
- States:
  - IDLE accepts an instruction when valid_in = 1.
  - MEM_WAIT holds a memory access.
  - HALTED is terminal until reset.
- R-type (00): next edge, wb_en = 1, wb_reg = instr[5:4], wb_data = alu_result_in. Latency 1.
- I-type (01), sub-op in instr[5:4]:
  - ADDI (00) and CMP (11): latency-1 writeback to rt = instr[3:2] with alu_result_in. CMP writes FF or 00 unchanged.
  - LD (01): next edge, dmem_req = 1, dmem_we = 0, dmem_addr = alu_result_in; go to MEM_WAIT.
  - ST (10): same as LD with dmem_we = 1 and dmem_wdata = write_data_in.
- MEM_WAIT:
  - req, we, addr and wdata are held stable until dmem_ack is sampled high.
  - An ack in the first req cycle is legal, giving the minimum 1-cycle wait.
  - On the ack edge: dmem_req = 0 and the state returns to IDLE.
  - LD: the same edge registers wb_en = 1, wb_reg = rt, wb_data = dmem_rdata.
  - ST: no writeback.
  - valid_in is ignored while stalled.
- JMP (10): next edge, redirect_valid = 1 and redirect_pc = pc_alu_in. No writeback.
- HALT (11): next edge, halted = 1 and the state goes to HALTED. stall_out stays 1 until reset; no further outputs.
- wb_en and redirect_valid are single-cycle pulses. wb_reg and wb_data hold their last value when wb_en = 0.
- Back-to-back non-memory instructions sustain one per cycle.
- A new instruction may be accepted in IDLE in the cycle immediately after an ack.
- Register 0 is an ordinary writeback destination.
- Widths: no arithmetic in this stage. dmem_addr is truncated or zero-extended to ADDR_W.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter starts at 0 when dmem_req rises.
  - When the counter reaches TIMEOUT_CYCLES-1 without an ack, the next edge drops dmem_req, sets mem_err (sticky) and returns to IDLE.
  - A timed-out LD writes back 0x00 to rt; a timed-out ST writes nothing.
  - An ack arriving on the final count wins over the timeout.
- Not defined: no counter; MEM_WAIT waits indefinitely; mem_err is tied 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode enum: OP_R, OP_I, OP_JMP, OP_HALT.
  - I sub-op enum: I_ADDI, I_LD, I_ST, I_CMP.
  - state enum: IDLE, MEM_WAIT, HALTED.
  - instruction field-slice constants.
- One natural sub-module, dmem_handshake: owns the req/ack hold, the ack capture and the optional timeout counter. It reports done/timed_out to the stage FSM.

Test Plan:
1. R-type ADD 00_01_10_00 with alu_result_in = 0x2A -> next cycle wb_en = 1, wb_reg = 1, wb_data = 0x2A; stall_out stays 0.
2. LD (0x5C) with alu_result_in = 0x40, ack after 3 req cycles with rdata = 0x99 -> dmem_req high 3 cycles at addr 0x40, we = 0; stall_out high throughout; wb_en pulse with wb_reg = 3, wb_data = 0x99.
3. ST with addr 0x10, write_data_in = 0x77, ack in the first req cycle -> one req cycle with we = 1, wdata = 0x77; no wb_en; the next instruction is accepted the following cycle.
4. JMP 0x85 with pc_alu_in = 0x05, then HALT -> redirect_valid pulse with redirect_pc = 0x05; then halted = 1 and stall_out = 1 permanently; later valid_in is ignored.
5. rst_n low during MEM_WAIT -> dmem_req = 0 immediately; no wb_en after release; state is IDLE.
6. (MEM_TIMEOUT_EN) LD with no ack -> req drops after 16 cycles; mem_err = 1; wb_data = 0x00 to rt.
